tlul_fifo_limiter: RTL and testbench

- Parametrised TL-UL buffering stage between a host and a slave device on the SRoT TileLink fabric.
- Contains a request FIFO on channel A and a response FIFO on channel D, each with configurable depth.
- Caps in-flight transactions at a programmable maximum, so an LLKI core never sees more outstanding requests than it can track.
- Bus field widths are generic and default to the CEP SRoT TileLink values.

---
 rtl/tlul_fifo_limiter.sv | 179 +++++++++++++++++
 tb/tb_tlul_fifo_limiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_fifo_limiter.sv
// TL-UL buffering stage: request and response FIFOs plus a cap on in-flight
// transactions so an LLKI slave never sees more outstanding requests than it tracks.

module tlul_fifo_limiter_fifo #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [Width-1:0] out_data,
    output logic             full
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    // Output comes straight from storage, so a new entry is visible one cycle after its push.
    assign full      = (count == FullCnt);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign do_push   = push && !full;
    assign do_pop    = pop && out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module tlul_fifo_limiter #(
    parameter int TL_DW          = 64,
    parameter int TL_AW          = 32,
    parameter int TL_AIW         = 4,
    parameter int TL_DIW         = 2,
    parameter int TL_SZW         = 3,
    parameter int ReqDepth       = 2,
    parameter int RspDepth       = 2,
    parameter int MaxOutstanding = 4,
    localparam int AW_P = 6 + TL_SZW + TL_AIW + TL_AW + TL_DW / 8 + TL_DW,
    localparam int DW_P = 7 + TL_SZW + TL_AIW + TL_DIW + TL_DW,
    localparam int CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            h_a_valid_i,
    output logic            h_a_ready_o,
    input  logic [AW_P-1:0] h_a_payload_i,
    output logic            d_a_valid_o,
    input  logic            d_a_ready_i,
    output logic [AW_P-1:0] d_a_payload_o,
    input  logic            d_d_valid_i,
    output logic            d_d_ready_o,
    input  logic [DW_P-1:0] d_d_payload_i,
    output logic            h_d_valid_o,
    input  logic            h_d_ready_i,
    output logic [DW_P-1:0] h_d_payload_o,
    output logic [CntW-1:0] outstanding_o,
    output logic            busy_o
);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    logic            running;
    logic            req_full;
    logic            rsp_full;
    logic            req_push;
    logic            rsp_push;
    logic            rsp_pop;
    logic [CntW-1:0] outstanding_q;
    logic [CntW-1:0] outstanding_d;
    logic            busy_q;

    // Readys are held low through reset and rise on the first clock after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    assign h_a_ready_o = running && !req_full && (outstanding_q < MaxCnt);
    assign d_d_ready_o = running && !rsp_full;

    assign req_push = h_a_valid_i && h_a_ready_o;
    assign rsp_push = d_d_valid_i && d_d_ready_o;
    assign rsp_pop  = h_d_valid_o && h_d_ready_i;

    tlul_fifo_limiter_fifo #(
        .Width (AW_P),
        .Depth (ReqDepth)
    ) u_req_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (req_push),
        .push_data (h_a_payload_i),
        .pop       (d_a_ready_i),
        .out_valid (d_a_valid_o),
        .out_data  (d_a_payload_o),
        .full      (req_full)
    );

    tlul_fifo_limiter_fifo #(
        .Width (DW_P),
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (rsp_push),
        .push_data (d_d_payload_i),
        .pop       (h_d_ready_i),
        .out_valid (h_d_valid_o),
        .out_data  (h_d_payload_o),
        .full      (rsp_full)
    );

    // Counted at the host side, so the cap covers both FIFOs and the device.
    always_comb begin
        outstanding_d = outstanding_q;
        if (req_push && !rsp_pop) begin
            if (outstanding_q != MaxCnt) begin
                outstanding_d = outstanding_q + 1'b1;
            end
        end else if (rsp_pop && !req_push) begin
            if (outstanding_q != '0) begin
                outstanding_d = outstanding_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            busy_q        <= (outstanding_d != '0);
        end
    end

    assign outstanding_o = outstanding_q;
    assign busy_o        = busy_q;

`ifndef SYNTHESIS
    // A response with nothing in flight means the device answered a request it never got.
    unsolicited_response: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rsp_pop && (outstanding_q == '0)));
`endif
endmodule

// File: tb/tb_tlul_fifo_limiter.sv
// Directed bench for tlul_fifo_limiter at default parameters (depths 2, cap 4).

module tb_tlul_fifo_limiter;
    localparam int AW_P = 117;
    localparam int DW_P = 80;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            h_a_valid;
    logic            h_a_ready;
    logic [AW_P-1:0] h_a_payload;
    logic            d_a_valid;
    logic            d_a_ready;
    logic [AW_P-1:0] d_a_payload;
    logic            d_d_valid;
    logic            d_d_ready;
    logic [DW_P-1:0] d_d_payload;
    logic            h_d_valid;
    logic            h_d_ready;
    logic [DW_P-1:0] h_d_payload;
    logic [2:0]      outstanding;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlul_fifo_limiter dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .h_a_valid_i   (h_a_valid),
        .h_a_ready_o   (h_a_ready),
        .h_a_payload_i (h_a_payload),
        .d_a_valid_o   (d_a_valid),
        .d_a_ready_i   (d_a_ready),
        .d_a_payload_o (d_a_payload),
        .d_d_valid_i   (d_d_valid),
        .d_d_ready_o   (d_d_ready),
        .d_d_payload_i (d_d_payload),
        .h_d_valid_o   (h_d_valid),
        .h_d_ready_i   (h_d_ready),
        .h_d_payload_o (h_d_payload),
        .outstanding_o (outstanding),
        .busy_o        (busy)
    );

    function automatic logic [AW_P-1:0] mk_a(input logic [2:0] op, input logic [3:0] src,
                                             input logic [31:0] addr, input logic [63:0] data);
        return {op, 3'd0, 3'd3, src, addr, 8'hFF, data};
    endfunction

    function automatic logic [DW_P-1:0] mk_d(input logic [2:0] op, input logic [3:0] src,
                                             input logic [63:0] data, input logic err);
        return {op, 3'd0, 3'd3, src, 2'd0, data, err};
    endfunction

    function automatic logic [AW_P-1:0] req_w(input int i);
        return mk_a(3'd0, 4'(i), 32'h7000_0100 + 32'(i * 8), 64'(i) * 64'h0101_0101_0101_0101);
    endfunction

    function automatic logic [DW_P-1:0] rsp_w(input int i);
        return mk_d(3'd0, 4'(i), 64'h1000 + 64'(i), 1'b0);
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic a_valid, input logic [AW_P-1:0] a_pay,
                                 input logic d_valid, input logic [DW_P-1:0] d_pay);
        h_a_valid   = a_valid;
        h_a_payload = a_pay;
        d_d_valid   = d_valid;
        d_d_payload = d_pay;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, 1'b1, mk_d(3'd1, 4'(i), 64'(i), 1'b0));
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        tick();
        tick();
    endtask

    logic [AW_P-1:0] get_req;
    logic [DW_P-1:0] get_rsp;
    logic [DW_P-1:0] err_rsp;

    initial begin
        rst_n     = 1'b0;
        d_a_ready = 1'b0;
        h_d_ready = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0);
        get_req = mk_a(3'd4, 4'd3, 32'h7000_0010, 64'h0);
        get_rsp = mk_d(3'd1, 4'd3, 64'hDEAD_BEEF_0123_4567, 1'b0);
        err_rsp = mk_d(3'd1, 4'd9, 64'h55AA, 1'b1);

        tick();
        tick();
        checkOutput("rst_h_a_ready", h_a_ready, 1'b0);
        checkOutput("rst_d_d_ready", d_d_ready, 1'b0);
        checkOutput("rst_d_a_valid", d_a_valid, 1'b0);
        checkOutput("rst_h_d_valid", h_d_valid, 1'b0);
        checkOutput("rst_outstanding", outstanding, 3'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_d_a_payload", d_a_payload, '0);
        checkOutput("rst_h_d_payload", h_d_payload, '0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_h_a_ready", h_a_ready, 1'b1);
        checkOutput("post_rst_d_d_ready", d_d_ready, 1'b1);

        // Single Get round trip
        d_a_ready = 1'b1;
        h_d_ready = 1'b1;
        applyStimulus(1'b1, get_req, 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("get_d_a_valid", d_a_valid, 1'b1);
        checkOutput("get_d_a_payload", d_a_payload, get_req);
        checkOutput("get_outstanding_t1", outstanding, 3'd1);
        checkOutput("get_busy_t1", busy, 1'b1);
        tick();
        checkOutput("get_d_a_drained", d_a_valid, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, get_rsp);
        checkOutput("get_d_d_ready", d_d_ready, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("get_h_d_valid", h_d_valid, 1'b1);
        checkOutput("get_h_d_payload", h_d_payload, get_rsp);
        checkOutput("get_outstanding_t4", outstanding, 3'd1);
        tick();
        checkOutput("get_outstanding_t5", outstanding, 3'd0);
        checkOutput("get_busy_t5", busy, 1'b0);
        checkOutput("get_h_d_drained", h_d_valid, 1'b0);

        // Outstanding cap: four requests, device silent
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, req_w(i), 1'b0, '0);
            checkOutput("cap_ready_before_limit", h_a_ready, 1'b1);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("cap_ready_at_limit", h_a_ready, 1'b0);
        checkOutput("cap_outstanding", outstanding, 3'd4);
        tick();
        checkOutput("cap_ready_held", h_a_ready, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, rsp_w(0));
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("cap_h_d_valid", h_d_valid, 1'b1);
        checkOutput("cap_ready_during_rsp", h_a_ready, 1'b0);
        tick();
        checkOutput("cap_outstanding_after_rsp", outstanding, 3'd3);
        checkOutput("cap_ready_restored", h_a_ready, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, rsp_w(1));
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        tick();
        checkOutput("sim_outstanding_start", outstanding, 3'd2);

        // Simultaneous host A and host D handshakes at count 2
        applyStimulus(1'b0, '0, 1'b1, err_rsp);
        tick();
        applyStimulus(1'b1, req_w(9), 1'b0, '0);
        checkOutput("sim_h_d_valid", h_d_valid, 1'b1);
        checkOutput("sim_error_passthrough", h_d_payload, err_rsp);
        checkOutput("sim_h_a_ready", h_a_ready, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("sim_outstanding_held", outstanding, 3'd2);
        checkOutput("sim_busy_held", busy, 1'b1);
        respond(2);
        checkOutput("sim_drained", outstanding, 3'd0);

        // Request FIFO fills while device stalls, then drains in order
        d_a_ready = 1'b0;
        applyStimulus(1'b1, mk_a(3'd4, 4'd1, 32'h10, 64'h0), 1'b0, '0);
        checkOutput("full_ready_0", h_a_ready, 1'b1);
        tick();
        applyStimulus(1'b1, mk_a(3'd4, 4'd2, 32'h20, 64'h0), 1'b0, '0);
        checkOutput("full_ready_1", h_a_ready, 1'b1);
        tick();
        applyStimulus(1'b1, mk_a(3'd4, 4'd3, 32'h30, 64'h0), 1'b0, '0);
        checkOutput("full_ready_low", h_a_ready, 1'b0);
        checkOutput("full_head_src1", d_a_payload, mk_a(3'd4, 4'd1, 32'h10, 64'h0));
        d_a_ready = 1'b1;
        tick();
        checkOutput("full_ready_back", h_a_ready, 1'b1);
        checkOutput("full_head_src2", d_a_payload, mk_a(3'd4, 4'd2, 32'h20, 64'h0));
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("full_head_src3", d_a_payload, mk_a(3'd4, 4'd3, 32'h30, 64'h0));
        checkOutput("full_outstanding", outstanding, 3'd3);
        tick();
        checkOutput("full_empty", d_a_valid, 1'b0);
        respond(3);
        checkOutput("full_drained", outstanding, 3'd0);

        // Back-to-back writes with responses echoed in the same cycle
        for (int k = 0; k < 19; k++) begin
            applyStimulus(k < 16, req_w(k), (k >= 1) && (k <= 16), rsp_w(k - 1));
            if (k < 16) checkOutput("tput_h_a_ready", h_a_ready, 1'b1);
            if (k >= 1 && k <= 16) begin
                checkOutput("tput_d_a_valid", d_a_valid, 1'b1);
                checkOutput("tput_d_a_payload", d_a_payload, req_w(k - 1));
            end else begin
                checkOutput("tput_d_a_idle", d_a_valid, 1'b0);
            end
            if (k >= 2 && k <= 17) begin
                checkOutput("tput_h_d_valid", h_d_valid, 1'b1);
                checkOutput("tput_h_d_payload", h_d_payload, rsp_w(k - 2));
            end else begin
                checkOutput("tput_h_d_idle", h_d_valid, 1'b0);
            end
            if (k >= 2 && k <= 16) checkOutput("tput_outstanding", outstanding, 3'd2);
            if (k == 17) checkOutput("tput_outstanding_tail", outstanding, 3'd1);
            if (k == 18) checkOutput("tput_outstanding_end", outstanding, 3'd0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, '0);

        // Reset with two requests queued
        d_a_ready = 1'b0;
        applyStimulus(1'b1, mk_a(3'd4, 4'd5, 32'h50, 64'h0), 1'b0, '0);
        tick();
        applyStimulus(1'b1, mk_a(3'd4, 4'd6, 32'h60, 64'h0), 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("mid_queued_valid", d_a_valid, 1'b1);
        checkOutput("mid_outstanding_before", outstanding, 3'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_d_a_valid", d_a_valid, 1'b0);
        checkOutput("mid_rst_h_d_valid", h_d_valid, 1'b0);
        checkOutput("mid_rst_outstanding", outstanding, 3'd0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_h_a_ready", h_a_ready, 1'b0);
        checkOutput("mid_rst_payload", d_a_payload, '0);
        tick();
        rst_n     = 1'b1;
        d_a_ready = 1'b1;
        tick();
        applyStimulus(1'b1, mk_a(3'd4, 4'd7, 32'h70, 64'h0), 1'b0, '0);
        checkOutput("mid_post_ready", h_a_ready, 1'b1);
        checkOutput("mid_post_empty", d_a_valid, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("mid_post_valid", d_a_valid, 1'b1);
        checkOutput("mid_post_payload", d_a_payload, mk_a(3'd4, 4'd7, 32'h70, 64'h0));
        checkOutput("mid_post_outstanding", outstanding, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
